// File: rtl/keypoint_collector_pkg.sv
// Shared state encodings, record layout and border test for the keypoint collector.
package keypoint_collector_pkg;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned REC_W   = X_W + Y_W + SCORE_W;
    localparam int unsigned COUNT_W = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SKIP  = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [SCORE_W-1:0] score;
    } kp_rec_t;

    // True when (x, y) lies inside the image with a margin of 'border' pixels on every side.
    function automatic logic in_window(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input int unsigned width, input int unsigned height,
                                       input int unsigned border);
        return (32'(x) >= border) && (32'(x) + border < width) &&
               (32'(y) >= border) && (32'(y) + border < height);
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// Synchronous record FIFO with full/empty flags; a pop frees its slot for a push in the same cycle.
module kp_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fill;
    logic              do_push, do_pop;

    assign full     = (fill == (AW + 1)'(DEPTH));
    assign empty    = (fill == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head reads as zero when empty so the outputs are clean straight out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fill <= fill + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/keypoint_collector.sv
// Turns the detector's per-pixel flag stream into queued {x, y, score} records, discarding
// border hits and dropping (with a sticky overflow) whatever the FIFO or per-frame cap refuses.
module keypoint_collector
    import keypoint_collector_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned OFFSET = 8,
    parameter int unsigned BORDER = 3,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MAX_KP = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_flag,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_kp_valid,
    input  logic               i_kp_ready,
    output logic [X_W-1:0]     o_kp_x,
    output logic [Y_W-1:0]     o_kp_y,
    output logic [SCORE_W-1:0] o_kp_score,
    output logic [COUNT_W-1:0] o_kp_count,
    output logic               o_overflow,
    output logic               o_frame_done
);

    localparam int unsigned SKIP_W = $clog2(OFFSET + 2);

    logic [2:0]         state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;

    logic    push, pop, fifo_full, fifo_empty, qualify, room;
    kp_rec_t push_rec, head_rec;

    assign pop      = !fifo_empty && i_kp_ready;
    assign qualify  = i_flag && in_window(x_q, y_q, WIDTH, HEIGHT, BORDER);
    // A full FIFO still takes a record when its head leaves in the same cycle.
    assign room     = (!fifo_full || pop) && (32'(count_q) < MAX_KP);
    assign push_rec = '{x: x_q, y: y_q, score: i_score};

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    // The start cycle itself is the first skipped position.
                    skip_d  = SKIP_W'(1);
                    state_d = (OFFSET > 1) ? ST_SKIP : ST_SCAN;
                end
            end
            ST_SKIP: begin
                if (skip_q >= SKIP_W'(OFFSET - 1)) begin
                    state_d = ST_SCAN;
                end else begin
                    skip_d = skip_q + SKIP_W'(1);
                end
            end
            ST_SCAN: begin
                if (qualify) begin
                    if (room) begin
                        push    = 1'b1;
                        count_d = count_q + COUNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (x_q == X_W'(WIDTH - 1)) begin
                    x_d = '0;
                    if (y_q == Y_W'(HEIGHT - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    kp_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(REC_W)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .push_data(push_rec),
        .pop      (pop),
        .pop_data (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_kp_valid   = !fifo_empty;
    assign o_kp_x       = head_rec.x;
    assign o_kp_y       = head_rec.y;
    assign o_kp_score   = head_rec.score;
    assign o_kp_count   = count_q;
    assign o_overflow   = ovf_q;
    assign o_frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_keypoint_collector.sv
// Two collectors (small FIFO / small cap) share one randomized stimulus stream; each has a
// frame-position reference model feeding a scoreboard that a negedge monitor drains.
module tb_keypoint_collector;
    import keypoint_collector_pkg::*;

    localparam int W         = 16;
    localparam int H         = 8;
    localparam int OFF       = 8;
    localparam int BRD       = 3;
    localparam int NPIX      = W * H;
    localparam int FRAME_LEN = OFF + NPIX;
    localparam int TAIL      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       flag = 1'b0;
    logic       kp_ready = 1'b0;
    logic [7:0] score = 8'h00;

    int checks = 0;
    int errors = 0;

    bit         flag_map  [NPIX];
    logic [7:0] score_map [NPIX];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int DEP  = (k == 0) ? 4 : 16;
        localparam int MAXK = (k == 0) ? 1024 : 2;

        logic        kp_valid, ovf, done;
        logic [9:0]  kp_x, kp_y;
        logic [7:0]  kp_score;
        logic [10:0] count;

        keypoint_collector #(
            .WIDTH (W),
            .HEIGHT(H),
            .OFFSET(OFF),
            .BORDER(BRD),
            .DEPTH (DEP),
            .MAX_KP(MAXK)
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start),
            .i_flag      (flag),
            .i_score     (score),
            .o_kp_valid  (kp_valid),
            .i_kp_ready  (kp_ready),
            .o_kp_x      (kp_x),
            .o_kp_y      (kp_y),
            .o_kp_score  (kp_score),
            .o_kp_count  (count),
            .o_overflow  (ovf),
            .o_frame_done(done)
        );

        // Model: pos = cycles since start (-1 idle, -2 the done cycle), occ = records held.
        kp_rec_t exp_q [$];
        int      pos  = -1;
        int      occ  = 0;
        int      mcnt = 0;
        bit      movf = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            int m_pos, m_occ, m_cnt, m_pix, m_x, m_y;
            bit m_ovf, m_pop;
            if (!rst_n) begin
                pos  <= -1;
                occ  <= 0;
                mcnt <= 0;
                movf <= 1'b0;
                exp_q.delete();
            end else begin
                m_pop = (occ > 0) && kp_ready;
                m_pos = pos;
                m_occ = occ;
                m_cnt = mcnt;
                m_ovf = movf;
                if (pos == -2) begin
                    m_pos = -1;
                end else if (pos == -1) begin
                    if (start) begin
                        m_pos = 1;
                        m_cnt = 0;
                        m_ovf = 1'b0;
                    end
                end else begin
                    m_pix = pos - OFF;
                    if (flag && m_pix >= 0 && m_pix < NPIX) begin
                        m_x = m_pix % W;
                        m_y = m_pix / W;
                        if (m_x >= BRD && m_x < W - BRD && m_y >= BRD && m_y < H - BRD) begin
                            if (m_cnt < MAXK && (occ < DEP || m_pop)) begin
                                exp_q.push_back('{x: 10'(m_x), y: 10'(m_y), score: score});
                                m_occ++;
                                m_cnt++;
                            end else begin
                                m_ovf = 1'b1;
                            end
                        end
                    end
                    m_pos = (m_pix >= NPIX && occ == 0) ? -2 : pos + 1;
                end
                if (m_pop) m_occ--;
                pos  <= m_pos;
                occ  <= m_occ;
                mcnt <= m_cnt;
                movf <= m_ovf;
            end
        end

        kp_rec_t held;
        kp_rec_t exp_rec;
        bit      hold = 1'b0;

        always @(negedge clk) begin
            check($sformatf("status%0d {valid,ovf,done,count}", k),
                  int'({kp_valid, ovf, done, count}),
                  int'({occ > 0, movf, pos == -2, 11'(mcnt)}));
            if (rst_n && hold) begin
                check($sformatf("stall_hold%0d", k), int'({kp_valid, kp_x, kp_y, kp_score}),
                      int'({1'b1, held}));
            end
            if (rst_n && kp_valid && kp_ready) begin
                check($sformatf("record_expected%0d", k), int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_rec = exp_q.pop_front();
                    check($sformatf("record%0d", k), int'({kp_x, kp_y, kp_score}),
                          int'(exp_rec));
                end
            end
            hold <= rst_n && kp_valid && !kp_ready;
            held <= '{x: kp_x, y: kp_y, score: kp_score};
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status_a"}, int'({g[0].kp_valid, g[0].ovf, g[0].done, g[0].count}), 0);
        check({tag, "_data_a"}, int'({g[0].kp_x, g[0].kp_y, g[0].kp_score}), 0);
        check({tag, "_status_b"}, int'({g[1].kp_valid, g[1].ovf, g[1].done, g[1].count}), 0);
        check({tag, "_data_b"}, int'({g[1].kp_x, g[1].kp_y, g[1].kp_score}), 0);
    endtask

    task automatic clear_map();
        foreach (flag_map[i]) begin
            flag_map[i]  = 1'b0;
            score_map[i] = 8'($urandom);
        end
    endtask

    task automatic set_flag(input int x, input int y, input logic [7:0] s);
        flag_map[y * W + x]  = 1'b1;
        score_map[y * W + x] = s;
    endtask

    // Drives one frame starting from an idle DUT; abort_idx >= 0 resets the DUTs at that cycle.
    task automatic run_frame(input int ready_from, input int ready_pct, input int abort_idx);
        for (int idx = 0; idx < FRAME_LEN + TAIL; idx++) begin
            if (idx == abort_idx) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort_reset");
                start    = 1'b0;
                flag     = 1'b0;
                kp_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            start = (idx == 0) || (idx < FRAME_LEN && $urandom_range(7) == 0);
            if (idx >= OFF && idx < FRAME_LEN) begin
                flag  = flag_map[idx - OFF];
                score = score_map[idx - OFF];
            end else begin
                flag  = 1'($urandom_range(1));
                score = 8'($urandom);
            end
            kp_ready = (idx >= FRAME_LEN) ||
                       (idx >= ready_from && $urandom_range(99) < ready_pct);
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        flag     = 1'b0;
        kp_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int ca, input int oa, input int cb,
                               input int ob);
        check({tag, "_count_a"}, int'(g[0].count), ca);
        check({tag, "_overflow_a"}, int'(g[0].ovf), oa);
        check({tag, "_count_b"}, int'(g[1].count), cb);
        check({tag, "_overflow_b"}, int'(g[1].ovf), ob);
    endtask

    initial begin
        #1;
        check_reset_outputs("power_on_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        clear_map();
        set_flag(5, 4, 8'h42);
        run_frame(0, 100, -1);
        check_frame("single", 1, 0, 1, 0);

        clear_map();
        set_flag(2, 4, 8'h11);
        set_flag(13, 4, 8'h22);
        set_flag(5, 1, 8'h33);
        set_flag(5, 5, 8'h44);
        run_frame(0, 100, -1);
        check_frame("border", 0, 0, 0, 0);

        // Ready held low for the whole scan, released at drain.
        clear_map();
        for (int x = 3; x <= 8; x++) set_flag(x, 3, 8'($urandom));
        run_frame(FRAME_LEN, 100, -1);
        check_frame("backpressure", 4, 1, 2, 1);

        clear_map();
        set_flag(3, 4, 8'hA1);
        set_flag(7, 4, 8'hA2);
        set_flag(12, 4, 8'hA3);
        run_frame(0, 100, -1);
        check_frame("cap", 3, 0, 2, 1);

        // Fill the small FIFO, then flag in the first cycle ready returns.
        clear_map();
        for (int x = 3; x <= 6; x++) set_flag(x, 3, 8'($urandom));
        set_flag(8, 3, 8'hC8);
        run_frame(OFF + 3 * W + 8, 100, -1);
        check_frame("full_pop_push", 5, 0, 2, 1);

        clear_map();
        for (int x = 3; x <= 5; x++) set_flag(x, 3, 8'($urandom));
        run_frame(FRAME_LEN + TAIL, 100, OFF + 3 * W + 8);
        check_frame("after_abort", 0, 0, 0, 0);

        repeat (4) begin
            foreach (flag_map[i]) begin
                flag_map[i]  = ($urandom_range(99) < 25);
                score_map[i] = 8'($urandom);
            end
            run_frame(int'($urandom_range(80)), int'($urandom_range(90, 20)), -1);
        end

        check("drained_a", g[0].exp_q.size(), 0);
        check("drained_b", g[1].exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
